// File: rtl/gauss_ctrl_pkg.sv
// gauss_ctrl_pkg: shared FSM type, counter widths and window constants for the Gaussian frame sequencer
package gauss_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  localparam int COL_W = $clog2(640);
  localparam int ROW_W = $clog2(480);
  localparam int WIN_SKIP = 2;
  localparam int FLT_LAT = 3;
endpackage

// File: rtl/pix_pos_cnt.sv
// pix_pos_cnt: column/row position of the current pixel beat within a W x H frame
//   clk, rst      clock, asynchronous active-high reset
//   clr           current beat is the first pixel of a frame (position forced to 0,0)
//   inc           current beat consumes a position
//   col, row      position of the current beat
//   last_col      current beat is the last column of its line
//   last_px       current beat is the last pixel of the frame
module pix_pos_cnt import gauss_ctrl_pkg::*; #(
  parameter int W = 640,
  parameter int H = 480,
  parameter int CW = COL_W,
  parameter int RW = ROW_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_col,
  output logic          last_px
);
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  always_comb begin
    col = clr ? '0 : col_q;
    row = clr ? '0 : row_q;
    last_col = col == CW'(W - 1);
    last_px = last_col && row == RW'(H - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (inc) begin
      col_q <= last_col ? '0 : col + CW'(1);
      row_q <= !last_col ? row : last_px ? '0 : row + RW'(1);
    end else if (clr) begin
      col_q <= '0;
      row_q <= '0;
    end
endmodule

// File: rtl/gauss_frame_ctrl.sv
// gauss_frame_ctrl: frame sequencer around a 3x3 Gaussian filter (framing checks, window masking, sop/eop regeneration)
//   clk, rst                      clock, asynchronous active-high reset
//   in_sop/in_eop/in_vld/in_data  grayscale pixel stream
//   flt_sop/flt_eop/flt_vld/flt_din           forward path to the filter (1 register stage)
//   flt_dout_sop/flt_dout_eop/flt_dout_vld/flt_dout  return path from the filter
//   out_sop/out_eop/out_vld/out_data          (IMG_W-2)x(IMG_H-2) output frame (1 register stage)
//   frame_err                     1-cycle pulse on a framing error
//   busy                          input FSM not in IDLE
//   bypass                        only with GAUSS_BYPASS_EN: per-frame filter bypass, sampled on sop
module gauss_frame_ctrl import gauss_ctrl_pkg::*; #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
`ifdef GAUSS_BYPASS_EN
  input  logic          bypass,
`endif
  output logic          flt_sop,
  output logic          flt_eop,
  output logic          flt_vld,
  output logic [DW-1:0] flt_din,
  input  logic          flt_dout_sop,
  input  logic          flt_dout_eop,
  input  logic          flt_dout_vld,
  input  logic [DW-1:0] flt_dout,
  output logic          out_sop,
  output logic          out_eop,
  output logic          out_vld,
  output logic [DW-1:0] out_data,
  output logic          frame_err,
  output logic          busy
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  state_t state, state_nx;
  logic acc, byp, bv, rv, ret_act, err_d, unused;
  logic [CW-1:0] icol, ocol;
  logic [RW-1:0] irow, orow;
  logic ilast_col, ilast_px, olast_col, olast_px;
  // a beat is taken only inside a frame or when it opens one
  assign acc = in_vld && (state != IDLE || in_sop);
  // return beats count only after a filter sop has opened the output frame
  assign rv = flt_dout_vld && (flt_dout_sop || ret_act);
  assign bv = acc && byp;
  assign unused = ^{icol, olast_col};
`ifdef GAUSS_BYPASS_EN
  logic byp_q;
  assign byp = (acc && in_sop) ? bypass : byp_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) byp_q <= 1'b0;
    else if (acc && in_sop) byp_q <= bypass;
`else
  assign byp = 1'b0;
`endif
  pix_pos_cnt #(.W(IMG_W), .H(IMG_H), .CW(CW), .RW(RW)) u_in_pos (
    .clk(clk), .rst(rst), .clr(acc && in_sop), .inc(acc),
    .col(icol), .row(irow), .last_col(ilast_col), .last_px(ilast_px)
  );
  pix_pos_cnt #(.W(IMG_W), .H(IMG_H), .CW(CW), .RW(RW)) u_out_pos (
    .clk(clk), .rst(rst), .clr(rv && flt_dout_sop), .inc(rv),
    .col(ocol), .row(orow), .last_col(olast_col), .last_px(olast_px)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // eop always closes the frame; sop (re)opens it, so sop+eop ends in IDLE
  always_comb
    state_nx = !acc ? state :
               in_eop ? IDLE :
               in_sop ? FILL :
               (state == FILL && irow == RW'(1) && ilast_col) ? RUN : state;
  always_comb begin
    busy = state != IDLE;
    err_d = acc && ((in_sop && busy) || (in_eop && !ilast_px));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      flt_sop <= 1'b0;
      flt_eop <= 1'b0;
      flt_vld <= 1'b0;
      flt_din <= '0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      out_vld <= 1'b0;
      out_data <= '0;
      frame_err <= 1'b0;
      ret_act <= 1'b0;
    end else begin
      flt_vld <= acc && !byp;
      flt_sop <= acc && !byp && in_sop;
      flt_eop <= acc && !byp && in_eop;
      flt_din <= in_data;
      frame_err <= err_d;
      if (rv) ret_act <= !(flt_dout_eop || olast_px);
      out_vld <= bv || (rv && orow >= RW'(WIN_SKIP) && ocol >= CW'(WIN_SKIP));
      out_sop <= bv ? in_sop : rv && orow == RW'(WIN_SKIP) && ocol == CW'(WIN_SKIP);
      out_eop <= bv ? in_eop : rv && olast_px;
      out_data <= bv ? in_data : flt_dout;
    end
endmodule

// File: tb/tb_gauss_frame_ctrl.sv
// tb_gauss_frame_ctrl: randomized directed bench with a frame-level reference model and a 3-cycle filter stand-in
module tb_gauss_frame_ctrl;
  localparam int W = 8, H = 6, N = W * H;
  typedef struct packed {logic sop; logic eop; logic [7:0] dat; logic [31:0] tim;} ev_t;
  logic clk = 1'b0, rst = 1'b1;
  logic in_sop = 1'b0, in_eop = 1'b0, in_vld = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic byp_in = 1'b0;
  logic flt_sop, flt_eop, flt_vld;
  logic [7:0] flt_din;
  logic flt_dout_sop, flt_dout_eop, flt_dout_vld;
  logic [7:0] flt_dout;
  logic out_sop, out_eop, out_vld, frame_err, busy;
  logic [7:0] out_data;
  logic [31:0] cyc = 0;
  int tests = 0, fails = 0;
  ev_t got[$], exp_q[$];
  int err_cnt = 0, fvld_cnt = 0;
  logic [1:0] err_fl = 2'b00;
  int m_err = 0, m_k = 0;
  bit m_act = 0, m_byp = 0;
  int gi = 0, ei = 0, err0 = 0, merr0 = 0, g = 0, f0 = 0;

  gauss_frame_ctrl #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .in_sop(in_sop), .in_eop(in_eop), .in_vld(in_vld), .in_data(in_data),
`ifdef GAUSS_BYPASS_EN
    .bypass(byp_in),
`endif
    .flt_sop(flt_sop), .flt_eop(flt_eop), .flt_vld(flt_vld), .flt_din(flt_din),
    .flt_dout_sop(flt_dout_sop), .flt_dout_eop(flt_dout_eop), .flt_dout_vld(flt_dout_vld), .flt_dout(flt_dout),
    .out_sop(out_sop), .out_eop(out_eop), .out_vld(out_vld), .out_data(out_data),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] fs, fe, fv;
  logic [2:0][7:0] fd;
  always @(posedge clk or posedge rst)
    if (rst) begin
      fs <= '0; fe <= '0; fv <= '0; fd <= '0;
    end else begin
      fs <= {fs[1:0], flt_sop};
      fe <= {fe[1:0], flt_eop};
      fv <= {fv[1:0], flt_vld};
      fd <= {fd[1:0], flt_din ^ 8'h5A};
    end
  assign flt_dout_sop = fs[2];
  assign flt_dout_eop = fe[2];
  assign flt_dout_vld = fv[2];
  assign flt_dout = fd[2];

  always @(negedge clk) begin
    if (out_vld) got.push_back('{sop: out_sop, eop: out_eop, dat: out_data, tim: cyc});
    if (frame_err) begin
      err_cnt++;
      err_fl = {flt_sop, flt_eop};
    end
    if (flt_vld) fvld_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // frame-level model: position = beats since sop, output window is rows/cols >= 2
  task automatic model(input logic s, input logic e, input logic [7:0] d);
    int r, c;
    if (!s && !m_act) return;
    if ((s && m_act) || (e && (s || m_k != N - 1))) m_err++;
    if (s) begin
      m_k = 0;
      m_act = 1;
      m_byp = byp_in;
    end
    r = m_k / W;
    c = m_k % W;
    if (m_byp) exp_q.push_back('{sop: s, eop: e, dat: d, tim: cyc + 1});
    else if (r >= 2 && c >= 2)
      exp_q.push_back('{sop: (r == 2 && c == 2), eop: (m_k == N - 1), dat: d ^ 8'h5A, tim: cyc + 5});
    if (e) m_act = 0;
    m_k = (m_k + 1) % N;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic s, input logic e);
    logic [7:0] d;
    d = 8'($urandom);
    in_sop = s; in_eop = e; in_data = d; in_vld = 1'b1;
    model(s, e, d);
    @(posedge clk); #1;
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send(input int n, input int sop_k, input int eop_k, input int gmin, input int gmax);
    for (int k = 0; k < n; k++) begin
      beat(k == sop_k, k == eop_k);
      idle($urandom_range(gmax, gmin));
    end
  endtask

  task automatic settle(input string tag);
    idle(12);
    check({tag, "_cnt"}, got.size() - gi, exp_q.size() - ei);
    for (int i = 0; i < exp_q.size() - ei && gi + i < got.size(); i++)
      check({tag, "_beat"}, got[gi + i], exp_q[ei + i]);
    check({tag, "_err"}, err_cnt - err0, m_err - merr0);
    gi = got.size(); ei = exp_q.size(); err0 = err_cnt; merr0 = m_err;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {out_sop, out_eop, out_vld, out_data, flt_sop, flt_eop, flt_vld, flt_din, frame_err, busy}, 0);
    rst = 1'b0;
    idle(2);
    check("idle_busy", busy, 0);
    send(4, -1, -1, 0, 2);
    settle("drop");
    check("drop_flt", fvld_cnt, 0);
    g = got.size();
    send(N, 0, N - 1, 0, 0);
    settle("t1");
    check("t1_n", got.size() - g, 24);
    check("t1_busy", busy, 0);
    g = got.size();
    send(N, 0, N - 1, 1, 3);
    settle("t2");
    check("t2_n", got.size() - g, 24);
    send(28, 0, -1, 0, 0);
    check("t3_busy", busy, 1);
    send(N, 0, N - 1, 0, 0);
    settle("t3");
    check("t3_fl", err_fl, 2'b10);
    send(47, 0, 46, 0, 1);
    check("t4_busy", busy, 0);
    settle("t4");
    check("t4_fl", err_fl, 2'b01);
    send(32, 0, -1, 0, 0);
    settle("t5a");
    check("t5_busy", busy, 1);
    rst = 1'b1;
    m_act = 0;
    idle(2);
    check("t5_rst", {out_sop, out_eop, out_vld, out_data, flt_sop, flt_eop, flt_vld, flt_din, frame_err, busy}, 0);
    rst = 1'b0;
    idle(1);
    send(3, -1, -1, 0, 0);
    send(N, 0, N - 1, 0, 1);
    settle("t5");
`ifdef GAUSS_BYPASS_EN
    f0 = fvld_cnt;
    g = got.size();
    byp_in = 1'b1;
    beat(1'b1, 1'b0);
    byp_in = 1'b0;
    send(N - 1, -1, N - 2, 0, 1);
    settle("t6");
    check("t6_n", got.size() - g, 48);
    check("t6_flt", fvld_cnt - f0, 0);
    send(N, 0, N - 1, 0, 0);
    settle("t6b");
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
